// File: rtl/reg_file_sb.sv
// reg_file_sb: DEPTH x DATA_WIDTH processor register file.
//   - two combinational read ports, one synchronous write port
//   - per-register pending (scoreboard) bit, set by RESERVE, cleared by WRITE
//   - CLEAR command that sweeps the file to zero, one register per cycle
// Optional feature macro: REG_BYPASS_EN
//   When defined, a write in IDLE is forwarded combinationally to any read
//   port addressing the same register, together with its next-state pending bit.
module reg_file_sb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [DATA_WIDTH-1:0] in_i,
    input  logic [ADDR_WIDTH-1:0] inaddress_i,
    input  logic                  write_i,
    input  logic                  reserve_i,
    input  logic [ADDR_WIDTH-1:0] resaddress_i,
    input  logic                  clear_i,
    input  logic [ADDR_WIDTH-1:0] out1address_i,
    input  logic [ADDR_WIDTH-1:0] out2address_i,
    output logic [DATA_WIDTH-1:0] out1_o,
    output logic [DATA_WIDTH-1:0] out2_o,
    output logic                  out1busy_o,
    output logic                  out2busy_o,
    output logic                  clearbusy_o
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // The counter carries one extra bit so the last sweep index compares
    // unambiguously against a full-width constant.
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_CLEARING = 1'b1
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [ADDR_WIDTH:0]     cnt_q;
    logic [ADDR_WIDTH:0]     cnt_d;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
    logic [DEPTH-1:0]        pend_q;
    logic [DEPTH-1:0]        pend_d;

    logic                    idle_s;
    logic                    sweep_s;
    logic [ADDR_WIDTH-1:0]   sweep_idx_s;

    logic [DEPTH-1:0]        wr_hit_s;
    logic [DEPTH-1:0]        res_hit_s;
    logic [DEPTH-1:0]        clr_hit_s;

    logic [DATA_WIDTH-1:0]   out1_s;
    logic [DATA_WIDTH-1:0]   out2_s;
    logic                    busy1_s;
    logic                    busy2_s;

    // FSM state and sweep counter registers, forced to IDLE/0 by reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic: CLEAR in IDLE starts a DEPTH-cycle sweep.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (clear_i) begin
                    state_d = ST_CLEARING;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEARING: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_CLEARING;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM outputs: IDLE accepts commands, CLEARING sweeps and reports busy.
    always_comb begin
        idle_s      = 1'b0;
        sweep_s     = 1'b0;
        sweep_idx_s = cnt_q[ADDR_WIDTH-1:0];
        case (state_q)
            ST_IDLE: begin
                idle_s  = 1'b1;
                sweep_s = 1'b0;
            end
            ST_CLEARING: begin
                idle_s  = 1'b0;
                sweep_s = 1'b1;
            end
            default: begin
                idle_s  = 1'b0;
                sweep_s = 1'b0;
            end
        endcase
    end

    assign clearbusy_o = sweep_s;

    // Per-register decode of write, reserve and sweep hits.
    always_comb begin
        wr_hit_s  = '0;
        res_hit_s = '0;
        clr_hit_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_hit_s[i]  = idle_s && write_i   && (inaddress_i  == ADDR_WIDTH'(i));
            res_hit_s[i] = idle_s && reserve_i && (resaddress_i == ADDR_WIDTH'(i));
            clr_hit_s[i] = sweep_s && (sweep_idx_s == ADDR_WIDTH'(i));
        end
    end

    // Next register contents and pending bits; reserve wins over a write.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i]  = mem_q[i];
            pend_d[i] = pend_q[i];
            if (clr_hit_s[i]) begin
                mem_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else if (wr_hit_s[i]) begin
                mem_d[i]  = in_i;
                pend_d[i] = res_hit_s[i];
            end else if (res_hit_s[i]) begin
                mem_d[i]  = mem_q[i];
                pend_d[i] = 1'b1;
            end else begin
                mem_d[i]  = mem_q[i];
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Storage and scoreboard registers, zeroed asynchronously by reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Combinational read ports, optionally forwarding the in-flight write.
    always_comb begin
        out1_s  = mem_q[out1address_i];
        busy1_s = pend_q[out1address_i];
        out2_s  = mem_q[out2address_i];
        busy2_s = pend_q[out2address_i];
`ifdef REG_BYPASS_EN
        if (idle_s && reset_ni && write_i && (out1address_i == inaddress_i)) begin
            out1_s  = in_i;
            busy1_s = reserve_i && (resaddress_i == inaddress_i);
        end else begin
            out1_s  = mem_q[out1address_i];
            busy1_s = pend_q[out1address_i];
        end
        if (idle_s && reset_ni && write_i && (out2address_i == inaddress_i)) begin
            out2_s  = in_i;
            busy2_s = reserve_i && (resaddress_i == inaddress_i);
        end else begin
            out2_s  = mem_q[out2address_i];
            busy2_s = pend_q[out2address_i];
        end
`endif
    end

    assign out1_o     = out1_s;
    assign out2_o     = out2_s;
    assign out1busy_o = busy1_s;
    assign out2busy_o = busy2_s;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: a constant vector table, hand-written
// clear/reset sequences, and randomized traffic against a reference model
// that keeps plain arrays plus a queue of register indices still to sweep.
module tb_reg_file_sb;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset_ni;
    logic [DW-1:0] in_i;
    logic [AW-1:0] inaddress_i;
    logic          write_i;
    logic          reserve_i;
    logic [AW-1:0] resaddress_i;
    logic          clear_i;
    logic [AW-1:0] out1address_i;
    logic [AW-1:0] out2address_i;
    logic [DW-1:0] out1_o;
    logic [DW-1:0] out2_o;
    logic          out1busy_o;
    logic          out2busy_o;
    logic          clearbusy_o;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .in_i          (in_i),
        .inaddress_i   (inaddress_i),
        .write_i       (write_i),
        .reserve_i     (reserve_i),
        .resaddress_i  (resaddress_i),
        .clear_i       (clear_i),
        .out1address_i (out1address_i),
        .out2address_i (out2address_i),
        .out1_o        (out1_o),
        .out2_o        (out2_o),
        .out1busy_o    (out1busy_o),
        .out2busy_o    (out2busy_o),
        .clearbusy_o   (clearbusy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model
    logic [DW-1:0] m_mem  [DEPTH];
    logic          m_pend [DEPTH];
    int            clr_q[$];

    // Values sampled by the last apply() call, before its clock edge
    logic [DW-1:0] s_o1, s_o2;
    logic          s_b1, s_b2, s_cb;

    typedef struct {
        logic we; int wa; int din; logic rs; int ra; logic cl; int a1; int a2;
        int o1; int o2; logic b1; logic b2; logic cb;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        clr_q.delete();
    endtask

    // One clock cycle: drive inputs, check reads before the edge, advance model.
    task automatic apply(input logic we, input int wa, input int din, input logic rs,
                         input int ra, input logic cl, input int a1, input int a2);
        logic [DW-1:0] e1, e2;
        logic          eb1, eb2;
        int            k;
        @(negedge clk);
        write_i       = we;
        inaddress_i   = AW'(wa);
        in_i          = DW'(din);
        reserve_i     = rs;
        resaddress_i  = AW'(ra);
        clear_i       = cl;
        out1address_i = AW'(a1);
        out2address_i = AW'(a2);
        #1;
        e1  = m_mem[a1];
        eb1 = m_pend[a1];
        e2  = m_mem[a2];
        eb2 = m_pend[a2];
`ifdef REG_BYPASS_EN
        if (clr_q.size() == 0 && we && a1 == wa) begin
            e1  = DW'(din);
            eb1 = rs && (ra == wa);
        end
        if (clr_q.size() == 0 && we && a2 == wa) begin
            e2  = DW'(din);
            eb2 = rs && (ra == wa);
        end
`endif
        check("out1", out1_o, e1);
        check("out2", out2_o, e2);
        check("out1busy", out1busy_o, eb1);
        check("out2busy", out2busy_o, eb2);
        check("clearbusy", clearbusy_o, clr_q.size() != 0);
        s_o1 = out1_o;
        s_o2 = out2_o;
        s_b1 = out1busy_o;
        s_b2 = out2busy_o;
        s_cb = clearbusy_o;
        @(posedge clk);
        if (clr_q.size() != 0) begin
            k = clr_q.pop_front();
            m_mem[k]  = '0;
            m_pend[k] = 1'b0;
        end else begin
            if (we) begin
                m_mem[wa]  = DW'(din);
                m_pend[wa] = 1'b0;
            end
            if (rs) begin
                m_pend[ra] = 1'b1;
            end
            if (cl) begin
                for (int i = 0; i < DEPTH; i++) clr_q.push_back(i);
            end
        end
    endtask

    // Short reset pulse between clock edges; outputs must drop at once.
    task automatic pulse_reset(input int a1, input int a2);
        @(negedge clk);
        write_i       = 1'b0;
        reserve_i     = 1'b0;
        clear_i       = 1'b0;
        out1address_i = AW'(a1);
        out2address_i = AW'(a2);
        #2 reset_ni = 1'b0;
        #1;
        check("rst_out1", out1_o, 0);
        check("rst_out2", out2_o, 0);
        check("rst_out1busy", out1busy_o, 0);
        check("rst_out2busy", out2busy_o, 0);
        check("rst_clearbusy", clearbusy_o, 0);
        model_reset();
        #1 reset_ni = 1'b1;
    endtask

    initial begin
        int cb_cnt;

        vecs[0] = '{1'b1, 2, 95, 1'b0, 0, 1'b0, 3, 0,  0,  0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 0,  0, 1'b1, 4, 1'b0, 2, 4, 95,  0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 0,  0, 1'b0, 0, 1'b0, 2, 4, 95,  0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 4,  6, 1'b0, 0, 1'b0, 2, 0, 95,  0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1, 28, 1'b1, 1, 1'b0, 4, 2,  6, 95, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 3, 77, 1'b1, 5, 1'b0, 1, 4, 28,  6, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 0,  0, 1'b0, 0, 1'b0, 3, 5, 77,  0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 0,  0, 1'b0, 0, 1'b0, 2, 1, 95, 28, 1'b0, 1'b1, 1'b0};

        reset_ni = 1'b0;
        in_i = '0; inaddress_i = '0; write_i = 1'b0; reserve_i = 1'b0;
        resaddress_i = '0; clear_i = 1'b0; out1address_i = '0; out2address_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init_out1", out1_o, 0);
        check("init_out1busy", out1busy_o, 0);
        check("init_clearbusy", clearbusy_o, 0);
        @(negedge clk);
        reset_ni = 1'b1;

        // Vector table: write/read, reserve, write-clears-pending, reserve wins
        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].we, vecs[i].wa, vecs[i].din, vecs[i].rs, vecs[i].ra,
                  vecs[i].cl, vecs[i].a1, vecs[i].a2);
            check("vec_out1", s_o1, vecs[i].o1);
            check("vec_out2", s_o2, vecs[i].o2);
            check("vec_busy1", s_b1, vecs[i].b1);
            check("vec_busy2", s_b2, vecs[i].b2);
            check("vec_clearbusy", s_cb, vecs[i].cb);
        end

        // Asynchronous reset mid-cycle with r2=95 and r1 pending
        apply(1'b0, 0, 0, 1'b0, 0, 1'b0, 2, 1);
        check("pre_rst_r2", s_o1, 95);
        pulse_reset(2, 1);
        apply(1'b0, 0, 0, 1'b0, 0, 1'b0, 2, 1);

        // Clear sweep: fill, clear, dropped commands, partial contents
        for (int i = 0; i < DEPTH; i++) apply(1'b1, i, 10 + i, 1'b0, 0, 1'b0, (i + 1) % 8, (i + 2) % 8);
        apply(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 7);
        check("clr_start_cb", s_cb, 0);
        apply(1'b1, 7, 50, 1'b0, 0, 1'b0, 0, 7);
        check("sweep1_r0", s_o1, 10);
        cb_cnt = int'(s_cb);
        apply(1'b1, 7, 50, 1'b1, 7, 1'b0, 0, 7);
        check("sweep2_r0", s_o1, 0);
        check("sweep2_r7", s_o2, 17);
        cb_cnt += int'(s_cb);
        for (int k = 0; k < 6; k++) begin
            apply(1'b1, 7, 50, 1'b1, 7, 1'b1, k, 7);
            cb_cnt += int'(s_cb);
        end
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 0, 0, 1'b0, 0, 1'b0, k % 8, 7);
            cb_cnt += int'(s_cb);
        end
        check("clearbusy_cycles", cb_cnt, 8);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 0, 0, 1'b0, 0, 1'b0, 2 * i, 2 * i + 1);
            check("post_clr_a", s_o1, 0);
            check("post_clr_b", s_o2, 0);
            check("post_clr_busy", s_b2, 0);
        end

        // Reset aborts a sweep; a fresh clear then takes the full length
        for (int i = 0; i < DEPTH; i++) apply(1'b1, i, 40 + i, 1'b1, i, 1'b0, 0, 1);
        apply(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 1);
        for (int k = 0; k < 3; k++) apply(1'b0, 0, 0, 1'b0, 0, 1'b0, 3, 4);
        check("abort_cb_before", s_cb, 1);
        pulse_reset(3, 4);
        for (int i = 0; i < DEPTH; i++) apply(1'b1, i, 60 + i, 1'b0, 0, 1'b0, 7 - i, 7 - i);
        apply(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 7);
        cb_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            apply(1'b0, 0, 0, 1'b0, 0, 1'b0, k % 8, 7);
            cb_cnt += int'(s_cb);
        end
        check("fresh_clear_cycles", cb_cnt, 8);

        // Write-through forwarding (or its absence)
        apply(1'b1, 6, 99, 1'b0, 0, 1'b0, 0, 1);
        apply(1'b1, 6, 15, 1'b0, 0, 1'b0, 6, 6);
`ifdef REG_BYPASS_EN
        check("bypass_out1", s_o1, 15);
`else
        check("nobypass_out1", s_o1, 99);
`endif
        apply(1'b0, 0, 0, 1'b0, 0, 1'b0, 6, 0);
        check("after_edge_out1", s_o1, 15);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            int wa, a1, a2;
            wa = int'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, 7));
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset(a1, a2);
            end else begin
                apply(1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 255)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      $urandom_range(0, 39) == 0, a1, a2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
